spike_aer_encoder: RTL and testbench



---
 rtl/spike_aer_encoder.sv | 162 ++++++++++++++++
 tb/tb_spike_aer_encoder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_aer_encoder.sv
// Address-event encoder for an LIF neuron array: spike edges become {neuron, timestamp}
// events, arbitrated round-robin into a first-word-fall-through FIFO on a valid/ready stream.
module spike_aer_encoder #(
  parameter int NUM_NEURONS = 4,
  parameter int ADDR_W      = 2,
  parameter int TS_W        = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_NEURONS-1:0]      spike_in,
  output logic                        ev_valid,
  input  logic                        ev_ready,
  output logic [ADDR_W-1:0]           ev_addr,
  output logic [TS_W-1:0]             ev_ts,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  input  logic                        overflow_clr,
  output logic [TS_W-1:0]             timestamp
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [TS_W-1:0]        ts_r;
  logic [NUM_NEURONS-1:0] prev_r;
  logic [NUM_NEURONS-1:0] pending_r;
  logic [TS_W-1:0]        pend_ts_r [NUM_NEURONS];
  logic [ADDR_W-1:0]      rr_ptr_r;
  logic [ADDR_W-1:0]      mem_addr_r [FIFO_DEPTH];
  logic [TS_W-1:0]        mem_ts_r [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_r;
  logic [PTR_W-1:0]       rd_ptr_r;
  logic [CNT_W-1:0]       count_r;
  logic                   valid_r;
  logic [ADDR_W-1:0]      head_addr_r;
  logic [TS_W-1:0]        head_ts_r;
  logic                   overflow_r;

  logic [NUM_NEURONS-1:0] edge_s;
  logic [NUM_NEURONS-1:0] gnt_onehot_s;
  logic [NUM_NEURONS-1:0] cap_s;
  logic                   drop_s;
  logic                   room_s;
  logic                   gnt_valid_s;
  logic [ADDR_W-1:0]      gnt_idx_s;
  logic                   push_s;
  logic                   pop_s;
  logic [PTR_W-1:0]       rd_next_s;
  logic [CNT_W-1:0]       count_next_s;
  logic [ADDR_W-1:0]      head_addr_next_s;
  logic [TS_W-1:0]        head_ts_next_s;

  assign edge_s = spike_in & ~prev_r;
  assign room_s = (count_r < CNT_W'(FIFO_DEPTH));
  // A re-edge is dropped only if the old event is still waiting; a granted slot frees up this cycle.
  assign drop_s = |(edge_s & pending_r & ~gnt_onehot_s);
  assign cap_s  = edge_s & ~(pending_r & ~gnt_onehot_s);
  assign push_s = gnt_valid_s;
  assign pop_s  = valid_r & ev_ready;

  // Round-robin search over pending slots starting at rr_ptr_r.
  always_comb begin
    int  idx_v;
    logic hit_v;
    gnt_valid_s  = 1'b0;
    gnt_idx_s    = '0;
    gnt_onehot_s = '0;
    idx_v        = 0;
    hit_v        = 1'b0;
    for (int k = 0; k < NUM_NEURONS; k++) begin
      idx_v = int'(rr_ptr_r) + k;
      idx_v = (idx_v >= NUM_NEURONS) ? (idx_v - NUM_NEURONS) : idx_v;
      hit_v = pending_r[idx_v] & room_s & ~gnt_valid_s;
      gnt_idx_s    = hit_v ? ADDR_W'(idx_v) : gnt_idx_s;
      gnt_onehot_s = hit_v ? (NUM_NEURONS'(1) << idx_v) : gnt_onehot_s;
      gnt_valid_s  = gnt_valid_s | hit_v;
    end
  end

  // Next FIFO read pointer, occupancy and head entry.
  always_comb begin
    rd_next_s = pop_s ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
    if (push_s && (rd_next_s == wr_ptr_r)) begin
      head_addr_next_s = gnt_idx_s;
      head_ts_next_s   = pend_ts_r[gnt_idx_s];
    end else begin
      head_addr_next_s = mem_addr_r[rd_next_s];
      head_ts_next_s   = mem_ts_r[rd_next_s];
    end
  end

  // Free-running timestamp, edge-detect history and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_r       <= '0;
      prev_r     <= '0;
      overflow_r <= 1'b0;
    end else begin
      ts_r       <= ts_r + TS_W'(1);
      prev_r     <= spike_in;
      overflow_r <= drop_s ? 1'b1 : (overflow_clr ? 1'b0 : overflow_r);
    end
  end

  // Per-neuron pending slots and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r <= '0;
      rr_ptr_r  <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) pend_ts_r[i] <= '0;
    end else begin
      pending_r <= edge_s | (pending_r & ~gnt_onehot_s);
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (cap_s[i]) pend_ts_r[i] <= ts_r;
      end
      if (gnt_valid_s) begin
        rr_ptr_r <= (int'(gnt_idx_s) == NUM_NEURONS - 1) ? '0 : (gnt_idx_s + ADDR_W'(1));
      end
    end
  end

  // Event FIFO storage, pointers and registered head outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      valid_r     <= 1'b0;
      head_addr_r <= '0;
      head_ts_r   <= '0;
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        mem_addr_r[j] <= '0;
        mem_ts_r[j]   <= '0;
      end
    end else begin
      if (push_s) begin
        mem_addr_r[wr_ptr_r] <= gnt_idx_s;
        mem_ts_r[wr_ptr_r]   <= pend_ts_r[gnt_idx_s];
        wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
      end
      rd_ptr_r    <= rd_next_s;
      count_r     <= count_next_s;
      valid_r     <= (count_next_s != '0);
      head_addr_r <= head_addr_next_s;
      head_ts_r   <= head_ts_next_s;
    end
  end

  assign ev_valid   = valid_r;
  assign ev_addr    = head_addr_r;
  assign ev_ts      = head_ts_r;
  assign fifo_count = count_r;
  assign overflow   = overflow_r;
  assign timestamp  = ts_r;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Directed bench for spike_aer_encoder: stimulus queues expected events, a negedge monitor
// pops and compares every accepted handshake.
module tb_spike_aer_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] spike_in = 4'b0000;
  logic       ev_ready = 1'b0;
  logic       overflow_clr = 1'b0;
  logic       ev_valid;
  logic [1:0] ev_addr;
  logic [7:0] ev_ts;
  logic [2:0] fifo_count;
  logic       overflow;
  logic [7:0] timestamp;

  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] ts;
  } ev_t;

  ev_t sb[$];
  int  total = 0;
  int  bad   = 0;

  spike_aer_encoder #(
    .NUM_NEURONS(4), .ADDR_W(2), .TS_W(8), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .spike_in(spike_in),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_addr(ev_addr), .ev_ts(ev_ts),
    .fifo_count(fifo_count), .overflow(overflow), .overflow_clr(overflow_clr),
    .timestamp(timestamp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input logic [1:0] a, input logic [7:0] t);
    ev_t e;
    e.addr = a;
    e.ts   = t;
    sb.push_back(e);
  endtask

  task automatic expect_burst(input logic [7:0] t);
    for (int i = 0; i < 4; i++) expect_ev(2'(i), t);
  endtask

  task automatic wait_ts(input logic [7:0] v);
    int n;
    n = 0;
    while (timestamp !== v && n < 300) begin
      tick();
      n++;
    end
    if (timestamp !== v) begin
      total++;
      bad++;
      $display("FAIL wait_ts: got %0d want %0d", timestamp, v);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Scoreboard monitor: each accepted event is compared with the oldest expected one.
  always @(negedge clk) begin
    ev_t e;
    if (!rst && ev_valid === 1'b1 && ev_ready === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got addr=%0d ts=%0d want none", ev_addr, ev_ts);
      end else begin
        e = sb.pop_front();
        check("ev_addr", 32'(ev_addr), 32'(e.addr));
        check("ev_ts", 32'(ev_ts), 32'(e.ts));
      end
    end
  end

  initial begin
    tick();
    tick();
    check("rst_valid", 32'(ev_valid), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_timestamp", 32'(timestamp), 32'd0);
    check("rst_addr", 32'(ev_addr), 32'd0);
    check("rst_ts", 32'(ev_ts), 32'd0);
    rst = 1'b0;

    // single spike, held 5 cycles, observed latency and hold under back-pressure
    wait_ts(8'd10);
    spike_in = 4'b0100;
    expect_ev(2'd2, 8'd10);
    tick();
    check("lat_valid_k", 32'(ev_valid), 32'd0);
    tick();
    check("lat_valid_k1", 32'(ev_valid), 32'd1);
    check("single_count", 32'(fifo_count), 32'd1);
    check("single_addr", 32'(ev_addr), 32'd2);
    check("single_ts", 32'(ev_ts), 32'd10);
    tick();
    tick();
    tick();
    spike_in = 4'b0000;
    tick();
    tick();
    check("single_one_event", 32'(fifo_count), 32'd1);
    check("single_hold_ts", 32'(ev_ts), 32'd10);
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    check("single_popped", 32'(ev_valid), 32'd0);
    check("single_sb", 32'(sb.size()), 32'd0);

    // simultaneous edges, two bursts
    reset_dut();
    ev_ready = 1'b1;
    wait_ts(8'd20);
    spike_in = 4'b1111;
    expect_burst(8'd20);
    tick();
    spike_in = 4'b0000;
    repeat (8) tick();
    check("burst20_sb", 32'(sb.size()), 32'd0);
    wait_ts(8'd40);
    spike_in = 4'b1111;
    expect_burst(8'd40);
    tick();
    spike_in = 4'b0000;
    repeat (8) tick();
    check("burst40_sb", 32'(sb.size()), 32'd0);

    // back-pressure: fill FIFO, fill pending, then third round is dropped
    reset_dut();
    ev_ready = 1'b0;
    wait_ts(8'd5);
    spike_in = 4'b1111;
    expect_burst(8'd5);
    tick();
    spike_in = 4'b0000;
    repeat (6) tick();
    check("bp_full_count", 32'(fifo_count), 32'd4);
    check("bp_full_no_ovf", 32'(overflow), 32'd0);
    wait_ts(8'd15);
    spike_in = 4'b1111;
    expect_burst(8'd15);
    tick();
    spike_in = 4'b0000;
    repeat (3) tick();
    check("bp_pend_count", 32'(fifo_count), 32'd4);
    check("bp_pend_no_ovf", 32'(overflow), 32'd0);
    wait_ts(8'd25);
    spike_in = 4'b1111;
    tick();
    spike_in = 4'b0000;
    tick();
    check("bp_drop_ovf", 32'(overflow), 32'd1);
    check("bp_drop_count", 32'(fifo_count), 32'd4);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("bp_ovf_clr", 32'(overflow), 32'd0);
    ev_ready = 1'b1;
    repeat (14) tick();
    check("bp_drain_sb", 32'(sb.size()), 32'd0);
    check("bp_drain_count", 32'(fifo_count), 32'd0);

    // re-edge on neuron 1 in the cycle it is granted
    reset_dut();
    ev_ready = 1'b1;
    wait_ts(8'd50);
    spike_in = 4'b0011;
    expect_ev(2'd0, 8'd50);
    expect_ev(2'd1, 8'd50);
    expect_ev(2'd1, 8'd52);
    tick();
    spike_in = 4'b0000;
    tick();
    spike_in = 4'b0010;
    tick();
    spike_in = 4'b0000;
    repeat (6) tick();
    check("regrant_no_ovf", 32'(overflow), 32'd0);
    check("regrant_sb", 32'(sb.size()), 32'd0);

    // timestamp wrap: edges at 255 and at 0
    wait_ts(8'd255);
    spike_in = 4'b0100;
    expect_ev(2'd2, 8'd255);
    tick();
    check("wrap_timestamp", 32'(timestamp), 32'd0);
    spike_in = 4'b1000;
    expect_ev(2'd3, 8'd0);
    tick();
    spike_in = 4'b0000;
    repeat (6) tick();
    check("wrap_sb", 32'(sb.size()), 32'd0);

    // async reset with three buffered events and neuron 0 held high
    ev_ready = 1'b0;
    spike_in = 4'b0111;
    tick();
    spike_in = 4'b0001;
    repeat (5) tick();
    check("ar_buffered", 32'(fifo_count), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid", 32'(ev_valid), 32'd0);
    check("ar_count", 32'(fifo_count), 32'd0);
    check("ar_timestamp", 32'(timestamp), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    expect_ev(2'd0, 8'd0);
    ev_ready = 1'b1;
    repeat (6) tick();
    check("ar_sb", 32'(sb.size()), 32'd0);
    check("ar_count_end", 32'(fifo_count), 32'd0);
    spike_in = 4'b0000;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
